psum_requant_writeback: RTL
===========================

Name: psum_requant_writeback

Overview:
- Downstream stage of the PE convolution core: drains the partial-sum buffer once the PE reports done.
- Per pixel: adds per-channel bias, applies rounding arithmetic right shift, optional ReLU and saturation to int8.
- Packs the 16 results and writes them into the next layer's activation buffer, one pixel per cycle, at full throughput.

Parameters:
NUM_CH, 16, channels per pixel word (psum lanes 32-bit, activation lanes 8-bit)
PSUM_AW, 10, psum buffer read address width
ACT_AW, 16, activation buffer write address width
READ_LATENCY, 1, psum BRAM read latency in cycles (1 or 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle start pulse; honoured only in IDLE
num_pixels  in  PSUM_AW+1  pixels to process (OUT_H*OUT_W); sampled at start
dst_base  in  ACT_AW  first activation-buffer address; sampled at start
shift  in  5  right-shift amount 0..31; sampled at start
relu_en  in  1  clamp negatives to 0; sampled at start
ch_mask  in  NUM_CH  lane enable; masked lanes write 0; sampled at start
bias  in  NUM_CH*32  signed per-channel bias, lane c at [c*32+:32]; static during a run
psum_addr  out  PSUM_AW  psum buffer read address (addrb)
psum_en  out  1  psum read enable
psum_dout  in  NUM_CH*32  psum read data (doutb), valid READ_LATENCY cycles after psum_en
act_addr  out  ACT_AW  activation buffer write address
act_din  out  NUM_CH*8  packed int8 result, lane c at [c*8+:8]
act_we  out  1  activation write strobe
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. The reset is asynchronous and may land mid-run. The run is abandoned, no further act_we is issued, and no done pulse follows.
- FSM has four states:
  - IDLE: on start with num_pixels>0, latch the config, clear the pixel counter, go to RUN. On start with num_pixels==0, go directly to DONE.
  - RUN: each cycle assert psum_en with psum_addr = counter, then increment the counter. After address num_pixels-1 is issued, go to DRAIN.
  - DRAIN: wait until the last pixel's act_we has been issued, then go to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- busy=1 in RUN, DRAIN and DONE.
- start is ignored while busy, including a start arriving in the same cycle as the done pulse.
- Pipeline, per pixel p: address issued at cycle t, psum_dout valid at t+READ_LATENCY, act_we for p asserted at t+READ_LATENCY+2.
  - Stage A registers the bias sum: s = sext33(psum) + sext33(bias).
  - Stage B registers the rounding shift, saturation and packing.
- Arithmetic per lane, all signed:
  - If shift>0: r = (s + 2^(shift-1)) >>> shift, computed in 34 bits. If shift==0: r = s.
  - If relu_en and r<0: r = 0.
  - Saturate r to [-128, 127].
  - If ch_mask[c]==0, the lane is 0.
- Write address: act_addr = dst_base + p, modulo 2^ACT_AW; wrap-around is permitted and silent.
- act_we is high for exactly num_pixels cycles, contiguous and in pixel order. act_addr and act_din are held stable only while act_we=1.
- done asserts in the cycle after the last act_we.
- Total run length from start to done: num_pixels + READ_LATENCY + 3 cycles.
- psum_en is never asserted outside RUN, so the psum buffer is never read beyond num_pixels-1.

Test Plan:
- Reset: rst_n=0 with random inputs -> all outputs 0. Release, num_pixels=4, shift=0, bias=0, psum lanes={5,-3,200,-200,...} -> act_din lanes {5,-3,127,-128}; 4 contiguous act_we at dst_base..dst_base+3; done at cycle 4+RL+3.
- Rounding/shift: psum=10, bias=1, shift=2 -> 3. psum=-10, bias=0, shift=2 -> -2. psum=6, shift=2 -> 2. relu_en=1 with psum=-50 -> 0.
- Full 8x8, COUT=10 layer: preload psum with golden convolution values, ch_mask=0x03FF, shift=4, relu_en=1 -> 64 writes matching the software model; lanes 10..15 equal 0.
- Edge counts: num_pixels=0 -> done one cycle after start, no act_we. num_pixels=1 -> one write. dst_base=0xFFFE with 4 pixels -> addresses FFFE, FFFF, 0000, 0001.
- Protocol: start re-pulsed while busy and on the done cycle -> ignored, exactly one run. Repeat the run with READ_LATENCY=2 -> identical data, latency one cycle longer.
- Async reset asserted in the middle of a 64-pixel run -> act_we and busy drop immediately, no done pulse. A new start afterwards completes a clean run.

Source files
------------

// File: rtl/psum_requant_writeback.sv
// Drains the partial-sum buffer after a PE run: bias add, rounding shift, ReLU,
// int8 saturation, then one packed activation word written per cycle.
module psum_requant_writeback #(
  parameter int NUM_CH       = 16,
  parameter int PSUM_AW      = 10,
  parameter int ACT_AW       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [PSUM_AW:0]       num_pixels,
  input  logic [ACT_AW-1:0]      dst_base,
  input  logic [4:0]             shift,
  input  logic                   relu_en,
  input  logic [NUM_CH-1:0]      ch_mask,
  input  logic [NUM_CH*32-1:0]   bias,
  output logic [PSUM_AW-1:0]     psum_addr,
  output logic                   psum_en,
  input  logic [NUM_CH*32-1:0]   psum_dout,
  output logic [ACT_AW-1:0]      act_addr,
  output logic [NUM_CH*8-1:0]    act_din,
  output logic                   act_we,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [PSUM_AW:0]        num_q, num_d;
  logic [4:0]              shift_q, shift_d;
  logic                    relu_q, relu_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [ACT_AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PSUM_AW-1:0]      psum_addr_q, psum_addr_d;
  logic                    psum_en_q, psum_en_d;
  logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic                    a_valid_q, a_valid_d;
  logic [32:0]             sum_q [NUM_CH];
  logic [32:0]             sum_d [NUM_CH];
  logic [7:0]              lane_res [NUM_CH];
  logic [ACT_AW-1:0]       act_addr_q, act_addr_d;
  logic [NUM_CH*8-1:0]     act_din_q, act_din_d;
  logic                    act_we_q, act_we_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    rd_valid;
  assign rd_valid = rd_pipe_q[READ_LATENCY-1];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    logic [31:0]        psum_l;
    logic [31:0]        bias_l;
    logic signed [33:0] ext_l;
    logic signed [33:0] rnd_l;
    logic signed [33:0] shr_l;
    logic [7:0]         res_l;

    assign psum_l     = psum_dout[gi*32 +: 32];
    assign bias_l     = bias[gi*32 +: 32];
    // Stage A: 33-bit sum cannot overflow for any pair of int32 operands.
    assign sum_d[gi]  = rd_valid ? ({psum_l[31], psum_l} + {bias_l[31], bias_l}) : sum_q[gi];

    // Stage B: round-half-up shift in 34 bits, then ReLU / saturate / mask.
    always_comb begin
      ext_l = {sum_q[gi][32], sum_q[gi]};
      rnd_l = ext_l;
      if (shift_q == 5'd0) begin
        shr_l = ext_l;
      end else begin
        rnd_l = ext_l + (34'sd1 <<< (shift_q - 5'd1));
        shr_l = rnd_l >>> shift_q;
      end
      if (!mask_q[gi])                res_l = 8'h00;
      else if (relu_q && shr_l[33])   res_l = 8'h00;
      else if (shr_l > 34'sd127)      res_l = 8'h7f;
      else if (shr_l < -34'sd128)     res_l = 8'h80;
      else                            res_l = shr_l[7:0];
    end

    assign lane_res[gi] = res_l;
  end

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    mask_d      = mask_q;
    wr_ptr_d    = wr_ptr_q;
    psum_addr_d = psum_addr_q;
    psum_en_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_d       = num_pixels;
          shift_d     = shift;
          relu_d      = relu_en;
          mask_d      = ch_mask;
          wr_ptr_d    = dst_base;
          psum_addr_d = '0;
          busy_d      = 1'b1;
          if (num_pixels == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = RUN;
            psum_en_d = 1'b1;
          end
        end
      end
      RUN: begin
        if ({1'b0, psum_addr_q} == num_q - (PSUM_AW+1)'(1)) begin
          state_d     = DRAIN;
          psum_addr_d = '0;
        end else begin
          psum_en_d   = 1'b1;
          psum_addr_d = psum_addr_q + PSUM_AW'(1);
        end
      end
      DRAIN: begin
        // Pixels are contiguous, so the last write is the one with nothing behind it.
        if (act_we_q && !a_valid_q && !(|rd_pipe_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    rd_pipe_d    = rd_pipe_q << 1;
    rd_pipe_d[0] = psum_en_q;
    a_valid_d    = rd_valid;
    act_we_d     = a_valid_q;
    act_addr_d   = act_addr_q;
    act_din_d    = act_din_q;
    if (a_valid_q) begin
      act_addr_d = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q + ACT_AW'(1);
      for (int c = 0; c < NUM_CH; c++) begin
        act_din_d[c*8 +: 8] = lane_res[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_q       <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      mask_q      <= '0;
      wr_ptr_q    <= '0;
      psum_addr_q <= '0;
      psum_en_q   <= 1'b0;
      rd_pipe_q   <= '0;
      a_valid_q   <= 1'b0;
      act_addr_q  <= '0;
      act_din_q   <= '0;
      act_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      mask_q      <= mask_d;
      wr_ptr_q    <= wr_ptr_d;
      psum_addr_q <= psum_addr_d;
      psum_en_q   <= psum_en_d;
      rd_pipe_q   <= rd_pipe_d;
      a_valid_q   <= a_valid_d;
      act_addr_q  <= act_addr_d;
      act_din_q   <= act_din_d;
      act_we_q    <= act_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_q[c] <= sum_d[c];
      end
    end
  end

  assign psum_addr = psum_addr_q;
  assign psum_en   = psum_en_q;
  assign act_addr  = act_addr_q;
  assign act_din   = act_din_q;
  assign act_we    = act_we_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
